// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register bank with one write port and two
// independently enabled, registered read ports. Entry 0 reads as zero.
// Optional same-edge write-to-read bypass: define REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic              r_en1,
  input  logic [ADDR_W-1:0] r_addr1,
  output logic [WIDTH-1:0]  r_data1,
  input  logic              r_en2,
  input  logic [ADDR_W-1:0] r_addr2,
  output logic [WIDTH-1:0]  r_data2
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NRD   = 2;

  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic [NRD-1:0][WIDTH-1:0]    rd_q, rd_d;
  logic [NRD-1:0]               rd_en;
  logic [NRD-1:0][ADDR_W-1:0]   rd_addr;
  logic                         wr_ok;

  // read ports handled as a small array so both share one description
  assign rd_en   = {r_en2, r_en1};
  assign rd_addr = {r_addr2, r_addr1};
  assign wr_ok   = w_en && (w_addr != '0);

  assign r_data1 = rd_q[0];
  assign r_data2 = rd_q[1];

  // next storage state: single write port, entry 0 pinned to zero
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[w_addr] = w_data;
    mem_d[0] = '0;
  end

  // next read data: enabled ports load, disabled ports hold
  always_comb begin
    rd_d = rd_q;
    for (int p = 0; p < NRD; p++) begin
      if (rd_en[p]) begin
        if (rd_addr[p] == '0) begin
          rd_d[p] = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        // same-edge write to the address being read forwards the new value
        else if (wr_ok && (w_addr == rd_addr[p])) begin
          rd_d[p] = w_data;
        end
`endif
        else begin
          rd_d[p] = mem_q[rd_addr[p]];
        end
      end
    end
  end

  // storage and read registers; async low reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file. Expected read data is pushed
// when a cycle is driven and popped after the edge that produces it.
module tb_reg_file;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic              r_en1, r_en2;
  logic [ADDR_W-1:0] r_addr1, r_addr2;
  logic [WIDTH-1:0]  r_data1, r_data2;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mdl [DEPTH];
  logic [WIDTH-1:0] h1, h2;
  logic [WIDTH-1:0] q1 [$];
  logic [WIDTH-1:0] q2 [$];
  logic [WIDTH-1:0] e1, e2;

  reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en1(r_en1), .r_addr1(r_addr1), .r_data1(r_data1),
    .r_en2(r_en2), .r_addr2(r_addr2), .r_data2(r_data2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    h1 = '0;
    h2 = '0;
    q1.delete();
    q2.delete();
  endtask

  function automatic logic [WIDTH-1:0] rd_model(input logic [ADDR_W-1:0] a,
      input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
    if (a == '0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mdl[a];
  endfunction

  // drive one cycle at the falling edge, push expected, return 1ns after rise
  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                      input logic e1i, input logic [ADDR_W-1:0] a1,
                      input logic e2i, input logic [ADDR_W-1:0] a2);
    @(negedge clk);
    w_en = we; w_addr = wa; w_data = wd;
    r_en1 = e1i; r_addr1 = a1; r_en2 = e2i; r_addr2 = a2;
    if (e1i) h1 = rd_model(a1, we, wa, wd);
    if (e2i) h2 = rd_model(a2, we, wa, wd);
    q1.push_back(h1);
    q2.push_back(h2);
    if (we && wa != '0) mdl[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    w_en = 1'b1; w_addr = 5'd3; w_data = 32'hDEADBEEF;
    r_en1 = 1'b1; r_addr1 = 5'd3; r_en2 = 1'b1; r_addr2 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if (r_data1 !== 32'h0) begin errors++; $display("FAIL reset_p1: got %h exp 0", r_data1); end
    if (r_data2 !== 32'h0) begin errors++; $display("FAIL reset_p2: got %h exp 0", r_data2); end
    @(negedge clk);
    reset = 1'b1; w_en = 1'b0;
    model_reset();
    step(0, 0, 0, 1, 3, 1, 3);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 3;
    if (r_data1 !== e1) begin errors++; $display("FAIL reset_rd3_p1: got %h exp %h", r_data1, e1); end
    if (r_data2 !== e2) begin errors++; $display("FAIL reset_rd3_p2: got %h exp %h", r_data2, e2); end
    if (r_data1 !== 32'h0) begin errors++; $display("FAIL reset_rd3_const: got %h exp 0", r_data1); end
  endtask

  task automatic test_write_read();
    step(1, 5, 32'h2, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    step(1, 6, 32'h4, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
    if (r_data1 !== e1) begin errors++; $display("FAIL wr_hold_p1: got %h exp %h", r_data1, e1); end
    if (r_data2 !== e2) begin errors++; $display("FAIL wr_hold_p2: got %h exp %h", r_data2, e2); end
    step(0, 0, 0, 1, 5, 1, 6);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 4;
    if (r_data1 !== e1) begin errors++; $display("FAIL wr_rd_p1: got %h exp %h", r_data1, e1); end
    if (r_data2 !== e2) begin errors++; $display("FAIL wr_rd_p2: got %h exp %h", r_data2, e2); end
    if (r_data1 !== 32'h2) begin errors++; $display("FAIL wr_rd_const1: got %h exp 2", r_data1); end
    if (r_data2 !== 32'h4) begin errors++; $display("FAIL wr_rd_const2: got %h exp 4", r_data2); end
  endtask

  task automatic test_enable_hold();
    step(1, 5, 32'h9, 0, 5, 0, 5);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
    if (r_data1 !== e1) begin errors++; $display("FAIL hold_p1: got %h exp %h", r_data1, e1); end
    if (r_data1 !== 32'h2) begin errors++; $display("FAIL hold_const: got %h exp 2", r_data1); end
    step(0, 0, 0, 1, 5, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 3;
    if (r_data1 !== e1) begin errors++; $display("FAIL hold_rd_p1: got %h exp %h", r_data1, e1); end
    if (r_data1 !== 32'h9) begin errors++; $display("FAIL hold_rd_const: got %h exp 9", r_data1); end
    if (r_data2 !== e2) begin errors++; $display("FAIL hold_p2: got %h exp %h", r_data2, e2); end
  endtask

  task automatic test_zero_reg();
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    step(1, 1, 32'h55, 1, 0, 1, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
    if (r_data1 !== 32'h0) begin errors++; $display("FAIL zero_p1: got %h exp 0", r_data1); end
    if (r_data2 !== 32'h0) begin errors++; $display("FAIL zero_p2: got %h exp 0", r_data2); end
    step(0, 1, 32'h7, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    step(0, 0, 0, 1, 1, 1, 1);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 3;
    if (r_data1 !== e1) begin errors++; $display("FAIL noen_p1: got %h exp %h", r_data1, e1); end
    if (r_data2 !== e2) begin errors++; $display("FAIL noen_p2: got %h exp %h", r_data2, e2); end
    if (r_data1 !== 32'h55) begin errors++; $display("FAIL noen_const: got %h exp 55", r_data1); end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] want;
`ifdef REG_FILE_BYPASS_EN
    want = 32'h22;
`else
    want = 32'h11;
`endif
    step(1, 7, 32'h11, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    step(1, 7, 32'h22, 1, 7, 1, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 3;
    if (r_data1 !== e1) begin errors++; $display("FAIL byp_p1: got %h exp %h", r_data1, e1); end
    if (r_data1 !== want) begin errors++; $display("FAIL byp_const: got %h exp %h", r_data1, want); end
    if (r_data2 !== 32'h0) begin errors++; $display("FAIL byp_zero_p2: got %h exp 0", r_data2); end
    step(0, 0, 0, 1, 7, 1, 7);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
    if (r_data1 !== 32'h22) begin errors++; $display("FAIL byp_next_p1: got %h exp 22", r_data1); end
    if (r_data2 !== 32'h22) begin errors++; $display("FAIL byp_next_p2: got %h exp 22", r_data2); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] wa, a1, a2;
    for (int i = 0; i < 60; i++) begin
      wa = ADDR_W'($urandom_range(0, DEPTH-1));
      a1 = (i % 4 == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH-1));
      a2 = ADDR_W'($urandom_range(0, DEPTH-1));
      step(1'($urandom_range(0, 1)), wa, $urandom(), 1'($urandom_range(0, 1)), a1,
           1'($urandom_range(0, 1)), a2);
      e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
      if (r_data1 !== e1) begin errors++; $display("FAIL rnd_p1[%0d]: got %h exp %h", i, r_data1, e1); end
      if (r_data2 !== e2) begin errors++; $display("FAIL rnd_p2[%0d]: got %h exp %h", i, r_data2, e2); end
    end
  endtask

  task automatic test_async_reset();
    step(1, 5, 32'hAA, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    step(1, 6, 32'hBB, 0, 0, 0, 0);
    e1 = q1.pop_front(); e2 = q2.pop_front();
    step(0, 0, 0, 1, 5, 1, 6);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
    if (r_data1 !== 32'hAA) begin errors++; $display("FAIL arst_pre_p1: got %h exp aa", r_data1); end
    if (r_data2 !== 32'hBB) begin errors++; $display("FAIL arst_pre_p2: got %h exp bb", r_data2); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (r_data1 !== 32'h0) begin errors++; $display("FAIL arst_now_p1: got %h exp 0", r_data1); end
    if (r_data2 !== 32'h0) begin errors++; $display("FAIL arst_now_p2: got %h exp 0", r_data2); end
    #1 reset = 1'b1;
    model_reset();
    step(0, 0, 0, 1, 5, 1, 6);
    e1 = q1.pop_front(); e2 = q2.pop_front(); checks += 2;
    if (r_data1 !== 32'h0) begin errors++; $display("FAIL arst_post_p1: got %h exp 0", r_data1); end
    if (r_data2 !== 32'h0) begin errors++; $display("FAIL arst_post_p2: got %h exp 0", r_data2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_enable_hold();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-entry register file: the successor to the single 32-bit load-enabled register, generalising it to DEPTH entries of WIDTH bits with one write port and two independently enabled, registered read ports. It is the datapath register bank feeding the ALU operand buses. Entry 0 is hardwired to zero. An optional write-to-read bypass is compiled in by macro.

## Interface
- WIDTH, 32, data width of every entry and port
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (default 32)
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low; low clears all state immediately
- w_en  input  1  write enable, sampled at rising clk
- w_addr  input  ADDR_W  write address
- w_data  input  WIDTH  write data
- r_en1  input  1  read-port-1 enable
- r_addr1  input  ADDR_W  read-port-1 address
- r_data1  output  WIDTH  read-port-1 data, registered
- r_en2  input  1  read-port-2 enable
- r_addr2  input  ADDR_W  read-port-2 address
- r_data2  output  WIDTH  read-port-2 data, registered

## Operation
- Storage: DEPTH x WIDTH flops; entry 0 is constant 0 and never written.
- Write: at rising clk with w_en=1 and w_addr!=0, entry[w_addr] <= w_data. w_en=0, or w_addr=0, leaves all entries unchanged.
- Read port k (k=1,2): at rising clk with r_enk=1, r_datak <= entry[r_addrk] (pre-edge contents, or bypassed value, see Configuration). r_enk=0 holds r_datak at its previous value.
- r_addrk=0 always returns 0, including under bypass.
- Ports independent: both read ports may address the same entry, or the entry being written, in the same cycle; no priority or stall.
- Reset (reset=0, any time, asynchronous): all entries and both r_data outputs go to 0 without waiting for clk; writes and reads are ignored while reset is low. First operation is accepted at the first rising clk with reset=1.
- Reset asserted mid-operation discards any write in flight; no partial update.
- No arithmetic; widths fixed by WIDTH/ADDR_W, no truncation or extension.

## Timing
- Reset value of every output: r_data1=0, r_data2=0.
- Write latency: value is in storage after the write edge; a read issued on the following edge returns it (read-after-write across cycles always correct).
- Read latency: 1 cycle; address and enable sampled at edge N, data valid after edge N, held until the next enabled read edge.
- Same-edge write and read of the same nonzero address: behaviour set by the bypass macro.
- No combinational path from any input to r_data1/r_data2.

## Configuration
- Macro REG_FILE_BYPASS_EN.
- Defined: same-edge read of address A with w_en=1, w_addr=A, A!=0 returns w_data (new value) on that port.
- Undefined: same case returns the old entry[A]; the new value is visible from the next read onward.
- Both builds: storage contents after the edge are identical; address 0 returns 0.

## Test plan
- Reset: hold reset=0 with w_en=1, w_addr=3, w_data=32'hDEADBEEF, r_en1=r_en2=1 across edges -> r_data1=r_data2=0; after release, read addr 3 -> 0.
- Write/read: write 32'h2 to addr 5, then 32'h4 to addr 6; next edge read r_addr1=5, r_addr2=6 -> r_data1=2, r_data2=4 one cycle later.
- Enable hold: r_data1=2 from addr 5; write 32'h9 to addr 5, r_en1=0 -> r_data1 stays 2; r_en1=1 -> r_data1=9 next edge.
- Zero register: write 32'hFFFFFFFF to addr 0, read addr 0 on both ports -> 0; w_en=0 write of 32'h7 to addr 1 -> addr 1 reads previous value.
- Bypass: addr 7 holds 32'h11; same edge w_addr=7, w_data=32'h22, r_addr1=7 -> r_data1=32'h22 with REG_FILE_BYPASS_EN, 32'h11 without; next read -> 32'h22 in both.
- Async reset mid-run: entries 5,6 loaded, drop reset between clock edges -> r_data1/r_data2 go 0 immediately; after release, reads of 5 and 6 return 0.
